// File: rtl/memaccess_stage_hs_pkg.sv
// Shared constants for the MemoryAccess stage: decoded-op field positions,
// funct3 access codes, fault bit indices and the FSM state type.
package memaccess_stage_hs_pkg;

  localparam int OPLEN_DEF       = 8;
  localparam int FUNCT3_BIT_L    = 0;
  localparam int FUNCT3_BIT_M    = 2;
  localparam int DATA_MEM_RE_BIT = 3;
  localparam int DATA_MEM_WE_BIT = 4;

  localparam int FAULT_ALIGN = 0;
  localparam int FAULT_BUS   = 1;

  localparam logic [2:0] FUNCT3_B  = 3'd0;
  localparam logic [2:0] FUNCT3_H  = 3'd1;
  localparam logic [2:0] FUNCT3_W  = 3'd2;
  localparam logic [2:0] FUNCT3_D  = 3'd3;
  localparam logic [2:0] FUNCT3_BU = 3'd4;
  localparam logic [2:0] FUNCT3_HU = 3'd5;
  localparam logic [2:0] FUNCT3_WU = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ma_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/memaccess_lane_align.sv
// Combinational lane handling: byte enables, lane-shifted store data,
// load shift plus sign/zero extension, and the legality check.
module memaccess_lane_align
  import memaccess_stage_hs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic              legal
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [OFFW-1:0] off;
  logic [1:0]      sz;
  logic [NB-1:0]   mask_nb;
  logic [XLEN-1:0] rep;
  logic [XLEN-1:0] sh;

  assign off     = addr_lo[OFFW-1:0];
  assign sz      = funct3[1:0];
  assign mask_nb = NB'(size_mask(sz));
  assign be      = mask_nb << off;
  assign wdata   = rep << {off, 3'b000};

  always_comb begin
    legal = 1'b1;
    case (sz)
      2'd1:    if (addr_lo[0])          legal = 1'b0;
      2'd2:    if (addr_lo[1:0] != '0)  legal = 1'b0;
      2'd3:    if (addr_lo[2:0] != '0)  legal = 1'b0;
      default: ;
    endcase
    if (funct3 == 3'd7)
      legal = 1'b0;
    if (is_store && funct3[2])
      legal = 1'b0;
    // 32-bit datapath has no doubleword or unsigned-word accesses
    if ((XLEN == 32) && ((funct3 == FUNCT3_D) || (funct3 == FUNCT3_WU)))
      legal = 1'b0;
  end

  always_comb begin
    case (sz)
      2'd0:    rep = {NB{wdata_in[7:0]}};
      2'd1:    rep = {(NB/2){wdata_in[15:0]}};
      2'd2:    rep = {(NB/4){wdata_in[31:0]}};
      default: rep = wdata_in;
    endcase
  end

  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (funct3)
      FUNCT3_B:  load_data = XLEN'($signed(sh[7:0]));
      FUNCT3_H:  load_data = XLEN'($signed(sh[15:0]));
      FUNCT3_W:  load_data = XLEN'($signed(sh[31:0]));
      FUNCT3_BU: load_data = XLEN'(sh[7:0]);
      FUNCT3_HU: load_data = XLEN'(sh[15:0]);
      FUNCT3_WU: load_data = XLEN'(sh[31:0]);
      default:   load_data = sh;
    endcase
  end

endmodule

// File: rtl/memaccess_stage_hs.sv
// MemoryAccess stage with req/ack data bus, multi-cycle wait, timeout and fault latch.
//   state   | meaning
//   ST_IDLE | no transaction outstanding; request issued combinationally for a legal mem op
//   ST_WAIT | request held until ack or timeout
module memaccess_stage_hs
  import memaccess_stage_hs_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OPLEN       = OPLEN_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_memoryaccess,
  input  logic [OPLEN-1:0]  decoded_op_em,
  input  logic              jump_state_em,
  input  logic [4:0]        rdsel_em,
  input  logic [XLEN-1:0]   next_pc_em,
  input  logic [XLEN-1:0]   alu_out_em,
  input  logic [XLEN-1:0]   rs2data_em,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [OPLEN-1:0]  decoded_op_mw,
  output logic              jump_state_mw,
  output logic [4:0]        rdsel_mw,
  output logic [XLEN-1:0]   next_pc_mw,
  output logic [XLEN-1:0]   alu_out_mw,
  output logic [XLEN-1:0]   mem_out_mw,
  output logic [1:0]        fault_mw,
  output logic              stall_memoryaccess
);

  localparam int OFFW = $clog2(XLEN / 8);

  ma_state_e       state, state_nxt;
  logic [7:0]      cnt;
  logic [2:0]      funct3;
  logic            load_en, store_en, mem_op, legal;
  logic            req_raw, done, bus_err;
  logic [XLEN-1:0] load_data;

  assign funct3   = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
  assign load_en  = decoded_op_em[DATA_MEM_RE_BIT];
  assign store_en = decoded_op_em[DATA_MEM_WE_BIT];
  assign mem_op   = phase_memoryaccess & (load_en | store_en);

  memaccess_lane_align #(.XLEN(XLEN)) u_align (
    .funct3   (funct3),
    .is_store (store_en),
    .addr_lo  (alu_out_em[2:0]),
    .wdata_in (rs2data_em),
    .rdata    (dmem_rdata),
    .be       (dmem_be),
    .wdata    (dmem_wdata),
    .load_data(load_data),
    .legal    (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // cnt tracks request-high cycles, counting the issue cycle in IDLE
      if (state_nxt == ST_IDLE)
        cnt <= '0;
      else if (state == ST_IDLE)
        cnt <= 8'd1;
      else
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    done      = 1'b0;
    bus_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && legal) begin
          req_raw = 1'b1;
          if (dmem_ack) done = 1'b1;
          else          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 8'(TIMEOUT_CYC)) begin
          done      = 1'b1;
          bus_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          req_raw = 1'b1;
          if (dmem_ack) begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset abandons any outstanding request immediately
  assign dmem_req           = req_raw & rst_n;
  assign dmem_we            = store_en & dmem_req;
  assign dmem_addr          = {alu_out_em[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign stall_memoryaccess = mem_op & legal & ~done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoded_op_mw <= '0;
      jump_state_mw <= 1'b0;
      rdsel_mw      <= '0;
      next_pc_mw    <= '0;
      alu_out_mw    <= '0;
      mem_out_mw    <= '0;
      fault_mw      <= '0;
    end else if (phase_memoryaccess && !stall_memoryaccess) begin
      decoded_op_mw         <= decoded_op_em;
      jump_state_mw         <= jump_state_em;
      rdsel_mw              <= rdsel_em;
      next_pc_mw            <= next_pc_em;
      alu_out_mw            <= alu_out_em;
      fault_mw[FAULT_BUS]   <= bus_err;
      fault_mw[FAULT_ALIGN] <= mem_op & ~legal;
      mem_out_mw            <= (load_en && done && !bus_err) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_memaccess_stage_hs.sv
// Bench for memaccess_stage_hs: one 32-bit and one 64-bit instance sharing stimulus,
// checked against a byte-level reference model.
module tb_memaccess_stage_hs;
  import memaccess_stage_hs_pkg::*;

  localparam int T32 = 255;
  localparam int T64 = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel64, phase, jump_t, ack;
  logic [7:0]  op_t;
  logic [4:0]  rdsel_t;
  logic [63:0] pc_t, addr_t, wd_t, rd_t;

  logic        req32, we32, jmp32, stall32;
  logic [3:0]  be32;
  logic [31:0] addr32, wdata32, pc32, alu32, mem32;
  logic [7:0]  op32;
  logic [4:0]  rdsel32;
  logic [1:0]  fault32;

  logic        req64, we64, jmp64, stall64;
  logic [7:0]  be64;
  logic [63:0] addr64, wdata64, pc64, alu64, mem64;
  logic [7:0]  op64;
  logic [4:0]  rdsel64;
  logic [1:0]  fault64;

  memaccess_stage_hs #(.XLEN(32), .TIMEOUT_CYC(T32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .phase_memoryaccess(phase & ~sel64),
    .decoded_op_em(op_t), .jump_state_em(jump_t), .rdsel_em(rdsel_t),
    .next_pc_em(pc_t[31:0]), .alu_out_em(addr_t[31:0]), .rs2data_em(wd_t[31:0]),
    .dmem_req(req32), .dmem_we(we32), .dmem_be(be32), .dmem_addr(addr32),
    .dmem_wdata(wdata32), .dmem_ack(ack), .dmem_rdata(rd_t[31:0]),
    .decoded_op_mw(op32), .jump_state_mw(jmp32), .rdsel_mw(rdsel32),
    .next_pc_mw(pc32), .alu_out_mw(alu32), .mem_out_mw(mem32),
    .fault_mw(fault32), .stall_memoryaccess(stall32)
  );

  memaccess_stage_hs #(.XLEN(64), .TIMEOUT_CYC(T64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .phase_memoryaccess(phase & sel64),
    .decoded_op_em(op_t), .jump_state_em(jump_t), .rdsel_em(rdsel_t),
    .next_pc_em(pc_t), .alu_out_em(addr_t), .rs2data_em(wd_t),
    .dmem_req(req64), .dmem_we(we64), .dmem_be(be64), .dmem_addr(addr64),
    .dmem_wdata(wdata64), .dmem_ack(ack), .dmem_rdata(rd_t),
    .decoded_op_mw(op64), .jump_state_mw(jmp64), .rdsel_mw(rdsel64),
    .next_pc_mw(pc64), .alu_out_mw(alu64), .mem_out_mw(mem64),
    .fault_mw(fault64), .stall_memoryaccess(stall64)
  );

  logic        req_o, we_o, stall_o, jmp_o;
  logic [7:0]  be_o;
  logic [63:0] addr_o, wdata_o, mem_o, alu_o;
  logic [4:0]  rdsel_o;
  logic [1:0]  fault_o;

  always_comb begin
    if (sel64) begin
      req_o = req64; we_o = we64; stall_o = stall64; be_o = be64;
      addr_o = addr64; wdata_o = wdata64; mem_o = mem64; alu_o = alu64;
      rdsel_o = rdsel64; fault_o = fault64; jmp_o = jmp64;
    end else begin
      req_o = req32; we_o = we32; stall_o = stall32; be_o = {4'b0, be32};
      addr_o = {32'b0, addr32}; wdata_o = {32'b0, wdata32}; mem_o = {32'b0, mem32};
      alu_o = {32'b0, alu32}; rdsel_o = rdsel32; fault_o = fault32; jmp_o = jmp32;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit ref_legal(bit is64, bit st, logic [2:0] f3, logic [63:0] addr);
    int bytes = 1 << f3[1:0];
    if (f3 == 3'd7) return 0;
    if (st && f3[2]) return 0;
    if (!is64 && (f3 == 3'd3 || f3 == 3'd6)) return 0;
    return (addr % bytes) == 0;
  endfunction

  function automatic logic [63:0] ref_be(bit is64, logic [2:0] f3, logic [63:0] addr);
    int nb = is64 ? 8 : 4;
    int bytes = 1 << f3[1:0];
    int off = int'(addr % nb);
    logic [63:0] m = ((64'd1 << bytes) - 64'd1) << off;
    return m & ((64'd1 << nb) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_wdata(bit is64, logic [2:0] f3, logic [63:0] addr, logic [63:0] d);
    int nb = is64 ? 8 : 4;
    int bytes = 1 << f3[1:0];
    int off = int'(addr % nb);
    logic [63:0] r = '0;
    for (int i = 0; i < nb; i++) r[i*8 +: 8] = d[(i % bytes)*8 +: 8];
    r = r << (off * 8);
    if (!is64) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [63:0] ref_load(bit is64, logic [2:0] f3, logic [63:0] addr, logic [63:0] rd);
    int nb = is64 ? 8 : 4;
    int bytes = 1 << f3[1:0];
    int off = int'(addr % nb);
    logic [63:0] w = is64 ? rd : (rd & 64'hFFFF_FFFF);
    logic [63:0] m = (bytes == 8) ? '1 : ((64'd1 << (bytes * 8)) - 64'd1);
    w = (w >> (off * 8)) & m;
    if (!f3[2] && bytes < 8 && ((w >> (bytes * 8 - 1)) & 64'd1) == 64'd1) w = w | ~m;
    if (!is64) w = w & 64'hFFFF_FFFF;
    return w;
  endfunction

  // ack_dly: cycles after the issue cycle before ack; negative means never
  task automatic run_access(input string tag, input bit is64, input bit st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] data,
                            input logic [63:0] rdata, input int ack_dly);
    bit ok = ref_legal(is64, st, f3, addr);
    int tmo = is64 ? T64 : T32;
    int req_cyc = 0;
    int stall_cyc = 0;
    bit fin = 0;
    int exp_req, exp_stall;
    logic [1:0]  exp_fault;
    logic [63:0] exp_mem;
    logic [4:0]  rs;

    if (!ok) begin
      exp_req = 0; exp_stall = 0; exp_fault = 2'b01;
    end else if (ack_dly < 0) begin
      exp_req = tmo; exp_stall = tmo; exp_fault = 2'b10;
    end else begin
      exp_req = ack_dly + 1; exp_stall = ack_dly; exp_fault = 2'b00;
    end
    exp_mem = (ok && !st && ack_dly >= 0) ? ref_load(is64, f3, addr, rdata) : 64'd0;

    rs = 5'($urandom_range(0, 31));
    sel64 = is64; op_t = {3'b000, st, ~st, f3}; addr_t = addr; wd_t = data; rd_t = rdata;
    rdsel_t = rs; pc_t = {$urandom, $urandom}; jump_t = 1'($urandom_range(0, 1)); phase = 1'b1;

    for (int k = 0; k < 600; k++) begin
      ack = (ack_dly >= 0) && (k == ack_dly);
      #1;
      if (k == 0 && ok) begin
        chk({tag, "_req"}, 64'(req_o), 64'd1);
        chk({tag, "_we"}, 64'(we_o), 64'(st));
        chk({tag, "_addr"}, addr_o, addr & ~64'(is64 ? 7 : 3));
        chk({tag, "_be"}, 64'(be_o), ref_be(is64, f3, addr));
        if (st) chk({tag, "_wdata"}, wdata_o, ref_wdata(is64, f3, addr, data));
      end
      if (req_o) req_cyc++;
      if (stall_o) stall_cyc++;
      else fin = 1;
      @(posedge clk); #1;
      if (fin) break;
    end
    phase = 1'b0; ack = 1'b0;
    #1;
    chk({tag, "_done"}, 64'(fin), 64'd1);
    chk({tag, "_reqcyc"}, 64'(req_cyc), 64'(exp_req));
    chk({tag, "_stallcyc"}, 64'(stall_cyc), 64'(exp_stall));
    chk({tag, "_fault"}, 64'(fault_o), 64'(exp_fault));
    chk({tag, "_memout"}, mem_o, exp_mem);
    chk({tag, "_rdsel"}, 64'(rdsel_o), 64'(rs));
    chk({tag, "_alu"}, alu_o, is64 ? addr : (addr & 64'hFFFF_FFFF));
    chk({tag, "_idle"}, 64'(req_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; sel64 = 1'b0; phase = 1'b0; ack = 1'b0; jump_t = 1'b0;
    op_t = '0; rdsel_t = '0; pc_t = '0; addr_t = '0; wd_t = '0; rd_t = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req32", 64'(req32), 64'd0);
    chk("rst_req64", 64'(req64), 64'd0);
    chk("rst_fault32", 64'(fault32), 64'd0);
    chk("rst_mem64", mem64, 64'd0);
    chk("rst_rdsel32", 64'(rdsel32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_access("sw_fast", 0, 1, FUNCT3_W, 64'h104, 64'hAABBCCDD, 64'd0, 0);
    run_access("sb_slow", 0, 1, FUNCT3_B, 64'h103, 64'h5A, 64'd0, 3);
    run_access("lb", 0, 0, FUNCT3_B, 64'h102, 64'd0, 64'h0080_0000, 1);
    run_access("lbu", 0, 0, FUNCT3_BU, 64'h102, 64'd0, 64'h0080_0000, 0);
    run_access("lh_mis", 0, 0, FUNCT3_H, 64'h101, 64'd0, 64'h1234_5678, 0);
    run_access("lw_tmo", 0, 0, FUNCT3_W, 64'h100, 64'd0, 64'hDEAD_BEEF, -1);
    run_access("ld32_ill", 0, 0, FUNCT3_D, 64'h108, 64'd0, 64'd0, 0);
    run_access("ld64", 1, 0, FUNCT3_D, 64'h8, 64'd0, 64'h8000_0000_0000_0001, 2);
    run_access("lwu64", 1, 0, FUNCT3_WU, 64'hC, 64'd0, 64'h8000_0000_0000_0000, 0);
    run_access("sd64", 1, 1, FUNCT3_D, 64'h10, 64'h0123_4567_89AB_CDEF, 64'd0, 1);
    run_access("ld64_tmo", 1, 0, FUNCT3_D, 64'h20, 64'd0, 64'd5, -1);

    for (int i = 0; i < 60; i++) begin
      bit is64 = 1'($urandom_range(0, 1));
      bit st = 1'($urandom_range(0, 1));
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [63:0] a = 64'h100 + 64'($urandom_range(0, 15));
      int d = (is64 && $urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      run_access("rnd", is64, st, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, d);
    end

    // Reset while a 64-bit load is waiting
    sel64 = 1'b1; op_t = {3'b000, 1'b0, 1'b1, FUNCT3_D}; addr_t = 64'h8; phase = 1'b1; ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rstwait_req_before", 64'(req64), 64'd1);
    chk("rstwait_stall_before", 64'(stall64), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait_req_after", 64'(req64), 64'd0);
    chk("rstwait_fault", 64'(fault64), 64'd0);
    phase = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_access("post_rst_lw", 1, 0, FUNCT3_W, 64'h104, 64'd0, 64'h8000_0000_0000_0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
